alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared external ALU: grant, hold operands for OP_LAT cycles, capture and return.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default build is round-robin.
module alu_arbiter #(
  parameter int OP_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [7:0]  req_op,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] rsp_data,
  output logic [4:0]  rsp_flags,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_opcode,
  input  logic [31:0] alu_out,
  input  logic [4:0]  alu_flags,
  output logic        busy,
  output logic        owner
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  localparam logic [2:0] LAT_M1 = 3'(OP_LAT - 1);

  state_t     state, next_state;
  logic [2:0] cnt;
  logic       winner;
  logic       prio;
  logic       accept;
  logic       exec_last;
  logic       rsp_done;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign prio = 1'b0;
`else
  logic ptr;

  // Pointer hands the next tie to whichever requester was not just served.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           ptr <= 1'b0;
    else if (rsp_done) ptr <= ~owner;
  end

  assign prio = ptr;
`endif

  // A lone requester wins outright; a tie goes to the priority index.
  always_comb begin
    winner = req_valid[1];
    if (req_valid == 2'b11) winner = prio;
  end

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // NOTE: every output of this block is defaulted first so no path can infer a latch.
  always_comb begin
    next_state = state;
    req_ready  = 2'b00;
    rsp_valid  = 2'b00;
    accept     = 1'b0;
    exec_last  = 1'b0;
    rsp_done   = 1'b0;
    unique case (state)
      IDLE: begin
        if (|req_valid && !rst) begin
          req_ready[winner] = 1'b1;
          accept            = 1'b1;
          next_state        = EXEC;
        end
      end
      EXEC: begin
        if (cnt == 3'd0) begin
          exec_last  = 1'b1;
          next_state = RESP;
        end
      end
      RESP: begin
        rsp_valid[owner] = 1'b1;
        if (rsp_ready[owner]) begin
          rsp_done   = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= 3'd0;
      owner      <= 1'b0;
      alu_a      <= 16'h0000;
      alu_b      <= 16'h0000;
      alu_opcode <= 4'h0;
      rsp_data   <= 32'h0000_0000;
      rsp_flags  <= 5'b00000;
    end else begin
      if (accept) begin
        owner      <= winner;
        alu_a      <= winner ? req_a[31:16] : req_a[15:0];
        alu_b      <= winner ? req_b[31:16] : req_b[15:0];
        alu_opcode <= winner ? req_op[7:4]  : req_op[3:0];
        cnt        <= LAT_M1;
      end else if (state == EXEC && cnt != 3'd0) begin
        cnt <= cnt - 3'd1;
      end
      // ALU has settled by the last EXEC cycle; the result is frozen until the next capture.
      if (exec_last) begin
        rsp_data  <= alu_out;
        rsp_flags <= alu_flags;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
